// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state enums and flag struct for alu_pipe
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NAND  = 4'd5,
    OP_NOR   = 4'd6,
    OP_SLT   = 4'd7,
    OP_SLTS  = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_SRA   = 4'd11,
    OP_MUL   = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } opcode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  // product is the accumulator after the final step, so the top can register it on done
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake, one op in flight
// ALU_PIPE_MUL_EN enables the iterative multiplier (opcode 12); otherwise opcode 12 is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             err
);

  opcode_e          op;
  logic             accept;
  logic             idle;
  logic             start_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  assign op     = opcode_e'(opcode);
  assign sh     = b[SHW-1:0];
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        alu_res            = sum[WIDTH-1:0];
        alu_flags.carry    = sum[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the unsigned borrow, i.e. a < b
        alu_res            = diff[WIDTH-1:0];
        alu_flags.carry    = diff[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  alu_res = a << sh;
      OP_SHR:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.negative = alu_res[WIDTH-1];
    alu_flags.zero     = (alu_res == '0);
  end

`ifdef ALU_PIPE_MUL_EN
  state_e             state_q, state_d;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  assign start_mul = accept && (op == OP_MUL);
  assign idle      = (state_q == ST_IDLE);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_mul) state_d = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
`else
  assign start_mul = 1'b0;
  assign idle      = 1'b1;
`endif

  assign in_ready = idle && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // a same-cycle accept overrides the pop, giving back-to-back results
    if (accept && !start_mul) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      flags_d     = alu_flags;
    end
`ifdef ALU_PIPE_MUL_EN
    if (mul_done) begin
      out_valid_d       = 1'b1;
      result_d          = product[WIDTH-1:0];
      flags_d           = '0;
      flags_d.carry     = |product[2*WIDTH-1:WIDTH];
      flags_d.negative  = product[WIDTH-1];
      flags_d.zero      = (product[WIDTH-1:0] == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign negative  = flags_q.negative;
  assign zero      = flags_q.zero;
  assign err       = flags_q.err;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It has WIDTH-bit operands, a 4-bit opcode, and valid/ready handshakes on both input and output. It adds signed compare, shifts and an iterative multi-cycle multiply. It sits between the operand issue logic and the writeback/flag consumer, and holds exactly one operation in flight.

Parameters:
WIDTH, 8, operand/result width; legal range 4..32, power of two
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  4  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry_out  output  1  carry (ADD), borrow (SUB), high-half-nonzero (MUL)
overflow  output  1  signed overflow (ADD/SUB only)
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0
err  output  1  illegal opcode

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n is low: state=IDLE; out_valid, result, carry_out, overflow, negative, zero and err are all 0. No stale output appears after reset is released.
- Input acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational and 1 immediately after reset.
  - An operation is accepted when in_valid && in_ready. a, b and opcode are captured only on accept.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR.
  - 7 SLT (unsigned), 8 SLTS (signed two's complement).
  - 9 SHL, 10 SHR (logical), 11 SRA. Shift amount = b[SHW-1:0]; upper bits of b are ignored.
  - 12 MUL (unsigned).
  - 13-15 illegal: result=0, err=1, all other flags computed from result (zero=1).
- Single-cycle ops (0-11, 13-15): the result register loads on the accept edge. out_valid rises the next cycle (latency 1).
- MUL FSM, states IDLE -> MUL_BUSY -> IDLE:
  - Accepting MUL enters MUL_BUSY and performs one shift-add step per cycle for WIDTH cycles.
  - On the last step, result = low WIDTH bits, carry_out = |high WIDTH bits, and out_valid rises. Latency is WIDTH+1 cycles from accept to out_valid.
  - in_ready is 0 throughout MUL_BUSY.
- Arithmetic flags:
  - ADD: {carry_out,result} = a+b, zero-extended.
  - SUB: result = a-b, carry_out = (a<b) unsigned borrow.
  - overflow: standard sign rule for ADD/SUB, 0 for all other ops.
  - SLT/SLTS: result = 1 or 0.
  - carry_out = 0 for every op other than ADD, SUB and MUL.
- Output hold: while out_valid && !out_ready, result and all flags hold stable.
- Output pop: out_valid drops after the pop unless a new operation is accepted in the same cycle. Accept and pop in the same cycle are legal; the new single-cycle result appears next cycle, giving back-to-back throughput of 1/cycle.
- Reset mid-MUL aborts the operation and produces no output.
- in_valid during MUL_BUSY is ignored. The source must hold it until in_ready.

Optional Feature:
Macro ALU_PIPE_MUL_EN.
- Defined: opcode 12 behaves as specified above (iterative MUL with the MUL_BUSY state).
- Undefined: no multiplier datapath and no MUL_BUSY state are built. Opcode 12 is treated as illegal: single-cycle, result=0, err=1.

Decomposition:
- Package alu_pkg holds:
  - opcode enum (ADD..MUL and the illegal range)
  - state enum
  - packed flags struct {carry, overflow, negative, zero, err}
- One sub-module is natural: alu_mul_seq (start/done shift-add multiplier, WIDTH-parametrised). It is instantiated only under ALU_PIPE_MUL_EN.

Test Plan:
- WIDTH=8, ADD a=0xFF, b=0x01 -> one cycle after accept: result=0x00, carry_out=1, zero=1, overflow=0.
- SUB a=0x80, b=0x01 -> result=0x7F, carry_out=0, overflow=1, negative=0.
- MUL a=0x10, b=0x11 (MUL_EN defined) -> result=0x10, carry_out=1, out_valid 9 cycles after accept, in_ready=0 during busy. With MUL_EN undefined -> result=0, err=1 after 1 cycle.
- Backpressure: ADD 3+4, out_ready held low 3 cycles -> result=0x07 stable, in_ready=0. Then out_ready=1 with in_valid XOR 0xF0^0xFF -> 0x0F on the next cycle, with no bubble.
- SRA a=0x90, b=0x02 -> 0xE4, negative=1. SLTS a=0xFF, b=0x01 -> 1. SLT with the same operands -> 0, zero=1.
- rst_n pulsed low mid-MUL -> out_valid=0 and flags 0 immediately. in_ready=1 after release; no result is emitted.
- Opcode 14 -> result=0, err=1, zero=1.
